// File: rtl/ct_ifu_predecd_array_ctrl.sv
// Request/response front end for the icache predecode array.
// Requests are queued in order. The single-port array pins are driven from
// registers. Read data returns through a small response FIFO. A credit check
// at issue time keeps that FIFO from ever overflowing.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. Ready never depends on valid. Once valid is raised, the
// payload stays stable until the transfer. req_vld/req_rdy carry requests in;
// rsp_vld/rsp_rdy carry read responses out.
module ct_ifu_predecd_array_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int REQ_DEPTH  = 2,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_index,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] rsp_index,
  output logic [ADDR_WIDTH-1:0] arr_index,
  output logic                  arr_cen_b,
  output logic                  arr_wen_b,
  output logic [DATA_WIDTH-1:0] arr_din,
  input  logic [DATA_WIDTH-1:0] arr_dout,
  output logic                  arr_clk_en,
  output logic                  ctrl_idle
);

  localparam int QPW = $clog2(REQ_DEPTH);
  localparam int QCW = $clog2(REQ_DEPTH + 1);
  localparam int RPW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int RCW = $clog2(RSP_DEPTH + 1) + 1;

  // request queue
  logic [REQ_DEPTH-1:0]  q_wr_q, q_wr_d;
  logic [ADDR_WIDTH-1:0] q_index_q [REQ_DEPTH];
  logic [ADDR_WIDTH-1:0] q_index_d [REQ_DEPTH];
  logic [DATA_WIDTH-1:0] q_wdata_q [REQ_DEPTH];
  logic [DATA_WIDTH-1:0] q_wdata_d [REQ_DEPTH];
  logic [QPW-1:0]        q_wptr_q, q_wptr_d, q_rptr_q, q_rptr_d;
  logic [QCW-1:0]        q_cnt_q, q_cnt_d;

  // array pins
  logic                  arr_cen_b_q, arr_cen_b_d;
  logic                  arr_wen_b_q, arr_wen_b_d;
  logic [ADDR_WIDTH-1:0] arr_index_q, arr_index_d;
  logic [DATA_WIDTH-1:0] arr_din_q, arr_din_d;
  logic                  clk_en_q, clk_en_d;

  // read pipeline: s1 = array samples next edge, s2 = dout valid, capture next edge
  logic                  rd_s1_q, rd_s1_d, rd_s2_q, rd_s2_d;
  logic [ADDR_WIDTH-1:0] rd_idx_s2_q, rd_idx_s2_d;

  // response FIFO
  logic [DATA_WIDTH-1:0] r_data_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] r_data_d [RSP_DEPTH];
  logic [ADDR_WIDTH-1:0] r_index_q [RSP_DEPTH];
  logic [ADDR_WIDTH-1:0] r_index_d [RSP_DEPTH];
  logic [RPW-1:0]        r_wptr_q, r_wptr_d, r_rptr_q, r_rptr_d;
  logic [RCW-1:0]        r_cnt_q, r_cnt_d;

  logic                  push, issue, head_wr, can_read, capture, rsp_pop;
  logic [RCW-1:0]        credit_used;

  assign req_rdy    = cpurst_b & (q_cnt_q < QCW'(REQ_DEPTH));
  assign rsp_vld    = (r_cnt_q != '0);
  assign rsp_rdata  = r_data_q[r_rptr_q];
  assign rsp_index  = r_index_q[r_rptr_q];
  assign arr_index  = arr_index_q;
  assign arr_cen_b  = arr_cen_b_q;
  assign arr_wen_b  = arr_wen_b_q;
  assign arr_din    = arr_din_q;
  assign arr_clk_en = clk_en_q;
  assign ctrl_idle  = (q_cnt_q == '0) & ~rd_s1_q & ~rd_s2_q & (r_cnt_q == '0);

  // Next-state logic: accept, in-order issue with read credit, capture, response pop
  always_comb begin
    push        = req_vld & req_rdy;
    head_wr     = q_wr_q[q_rptr_q];
    // reads already in the pipe plus buffered responses must leave a free slot
    credit_used = r_cnt_q + RCW'(rd_s1_q) + RCW'(rd_s2_q);
    can_read    = credit_used < RCW'(RSP_DEPTH);
    issue       = (q_cnt_q != '0) & (head_wr | can_read);
    capture     = rd_s2_q;
    rsp_pop     = rsp_vld & rsp_rdy;

    q_wr_d    = q_wr_q;
    q_index_d = q_index_q;
    q_wdata_d = q_wdata_q;
    q_wptr_d  = q_wptr_q;
    q_rptr_d  = q_rptr_q;
    if (push) begin
      q_wr_d[q_wptr_q]    = req_wr;
      q_index_d[q_wptr_q] = req_index;
      q_wdata_d[q_wptr_q] = req_wdata;
      q_wptr_d            = q_wptr_q + 1'b1;
    end
    if (issue) q_rptr_d = q_rptr_q + 1'b1;
    q_cnt_d = q_cnt_q + QCW'(push) - QCW'(issue);

    arr_cen_b_d = ~issue;
    arr_wen_b_d = ~(issue & head_wr);
    arr_index_d = issue ? q_index_q[q_rptr_q] : arr_index_q;
    arr_din_d   = (issue & head_wr) ? q_wdata_q[q_rptr_q] : arr_din_q;

    rd_s1_d     = issue & ~head_wr;
    rd_s2_d     = rd_s1_q;
    rd_idx_s2_d = rd_s1_q ? arr_index_q : rd_idx_s2_q;

    r_data_d  = r_data_q;
    r_index_d = r_index_q;
    r_wptr_d  = r_wptr_q;
    r_rptr_d  = r_rptr_q;
    if (capture) begin
      r_data_d[r_wptr_q]  = arr_dout;
      r_index_d[r_wptr_q] = rd_idx_s2_q;
      r_wptr_d = (r_wptr_q == RPW'(RSP_DEPTH - 1)) ? '0 : r_wptr_q + 1'b1;
    end
    if (rsp_pop) r_rptr_d = (r_rptr_q == RPW'(RSP_DEPTH - 1)) ? '0 : r_rptr_q + 1'b1;
    r_cnt_d = r_cnt_q + RCW'(capture) - RCW'(rsp_pop);

    // the array clock stays on while work is queued, a read is in the pipe or an access is launched
    clk_en_d = (q_cnt_d != '0) | rd_s1_d | rd_s2_d | issue;
  end

  // State registers; reset drops queued and in-flight work
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      q_wr_q      <= '0;
      q_wptr_q    <= '0;
      q_rptr_q    <= '0;
      q_cnt_q     <= '0;
      for (int i = 0; i < REQ_DEPTH; i++) begin
        q_index_q[i] <= '0;
        q_wdata_q[i] <= '0;
      end
      arr_cen_b_q <= 1'b1;
      arr_wen_b_q <= 1'b1;
      arr_index_q <= '0;
      arr_din_q   <= '0;
      clk_en_q    <= 1'b0;
      rd_s1_q     <= 1'b0;
      rd_s2_q     <= 1'b0;
      rd_idx_s2_q <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        r_data_q[i]  <= '0;
        r_index_q[i] <= '0;
      end
      r_wptr_q    <= '0;
      r_rptr_q    <= '0;
      r_cnt_q     <= '0;
    end else begin
      q_wr_q      <= q_wr_d;
      q_index_q   <= q_index_d;
      q_wdata_q   <= q_wdata_d;
      q_wptr_q    <= q_wptr_d;
      q_rptr_q    <= q_rptr_d;
      q_cnt_q     <= q_cnt_d;
      arr_cen_b_q <= arr_cen_b_d;
      arr_wen_b_q <= arr_wen_b_d;
      arr_index_q <= arr_index_d;
      arr_din_q   <= arr_din_d;
      clk_en_q    <= clk_en_d;
      rd_s1_q     <= rd_s1_d;
      rd_s2_q     <= rd_s2_d;
      rd_idx_s2_q <= rd_idx_s2_d;
      r_data_q    <= r_data_d;
      r_index_q   <= r_index_d;
      r_wptr_q    <= r_wptr_d;
      r_rptr_q    <= r_rptr_d;
      r_cnt_q     <= r_cnt_d;
    end
  end

endmodule

// File: tb/tb_ct_ifu_predecd_array_ctrl.sv
// Bench for ct_ifu_predecd_array_ctrl: array emulation, transaction-level
// reference model, per-cycle compare and directed plus random stimulus.
module tb_ct_ifu_predecd_array_ctrl;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int RQD = 2;
  localparam int RSD = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_vld = 1'b0, req_wr = 1'b0, rsp_rdy = 1'b1;
  logic [AW-1:0] req_index = '0;
  logic [DW-1:0] req_wdata = '0, arr_dout = '0;
  logic          req_rdy, rsp_vld, arr_cen_b, arr_wen_b, arr_clk_en, ctrl_idle;
  logic [DW-1:0] rsp_rdata, arr_din;
  logic [AW-1:0] rsp_index, arr_index;

  ct_ifu_predecd_array_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REQ_DEPTH(RQD), .RSP_DEPTH(RSD)) dut (
    .forever_cpuclk(clk), .cpurst_b(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_index(req_index), .req_wdata(req_wdata),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_index(rsp_index),
    .arr_index(arr_index), .arr_cen_b(arr_cen_b), .arr_wen_b(arr_wen_b), .arr_din(arr_din),
    .arr_dout(arr_dout), .arr_clk_en(arr_clk_en), .ctrl_idle(ctrl_idle)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int rdy_mode = 0;   // 0: rsp_rdy=1, 1: rsp_rdy=0, 2: random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // single-port array emulation: samples pins on the rising edge, read data valid after it
  logic [DW-1:0] arr_mem [int];
  always @(posedge clk) begin
    if (arr_cen_b === 1'b0) begin
      if (arr_wen_b === 1'b0) arr_mem[int'(arr_index)] = arr_din;
      else arr_dout <= arr_mem.exists(int'(arr_index)) ? arr_mem[int'(arr_index)] : '0;
    end
  end

  // reference model: request list, reads in flight with due cycle, response list
  typedef struct { logic wr; logic [AW-1:0] idx; logic [DW-1:0] data; } req_t;
  typedef struct { logic [AW-1:0] idx; logic [DW-1:0] data; int due; } rd_t;
  req_t          mq[$];
  rd_t           flight[$];
  rd_t           rspq[$];
  logic [DW-1:0] gold [int];
  logic          m_cen_b = 1'b1, m_wen_b = 1'b1, m_clk_en = 1'b0;
  logic [AW-1:0] m_index = '0;
  logic [DW-1:0] m_din = '0;
  int            m_cyc = 0;
  bit            do_pop, do_push, do_issue;
  req_t          mh;
  rd_t           mr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); flight.delete(); rspq.delete();
      m_cen_b = 1'b1; m_wen_b = 1'b1; m_index = '0; m_din = '0; m_clk_en = 1'b0;
    end else begin
      m_cyc++;
      do_pop   = (rspq.size() > 0) && rsp_rdy;
      do_push  = req_vld && (mq.size() < RQD);
      do_issue = (mq.size() > 0) && (mq[0].wr || (flight.size() + rspq.size() < RSD));
      if (do_pop) void'(rspq.pop_front());
      while (flight.size() > 0 && flight[0].due == m_cyc) rspq.push_back(flight.pop_front());
      m_cen_b = 1'b1;
      m_wen_b = 1'b1;
      if (do_issue) begin
        mh = mq.pop_front();
        m_cen_b = 1'b0;
        m_index = mh.idx;
        if (mh.wr) begin
          m_wen_b = 1'b0;
          m_din   = mh.data;
          gold[int'(mh.idx)] = mh.data;
        end else begin
          mr.idx  = mh.idx;
          mr.data = gold.exists(int'(mh.idx)) ? gold[int'(mh.idx)] : '0;
          mr.due  = m_cyc + 2;
          flight.push_back(mr);
        end
      end
      if (do_push) begin
        mh.wr = req_wr; mh.idx = req_index; mh.data = req_wdata;
        mq.push_back(mh);
      end
      m_clk_en = (mq.size() > 0) || (flight.size() > 0) || do_issue;
    end
  end

  // compare process: every output against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_rdy", req_rdy, rst_n && (mq.size() < RQD));
      check("rsp_vld", rsp_vld, rspq.size() > 0);
      if (rspq.size() > 0) begin
        check("rsp_rdata", rsp_rdata, rspq[0].data);
        check("rsp_index", rsp_index, rspq[0].idx);
      end
      check("arr_cen_b", arr_cen_b, m_cen_b);
      check("arr_wen_b", arr_wen_b, m_wen_b);
      check("arr_index", arr_index, m_index);
      check("arr_din", arr_din, m_din);
      check("arr_clk_en", arr_clk_en, m_clk_en);
      check("ctrl_idle", ctrl_idle, mq.size() == 0 && flight.size() == 0 && rspq.size() == 0);
    end
  end

  // response log for directed literal checks
  logic [AW+DW-1:0] got[$];
  always @(posedge clk) if (rst_n && rsp_vld && rsp_rdy) got.push_back({rsp_index, rsp_rdata});

  // rsp_rdy driver
  always @(negedge clk) begin
    case (rdy_mode)
      0:       rsp_rdy = 1'b1;
      1:       rsp_rdy = 1'b0;
      default: rsp_rdy = ($urandom_range(0, 3) != 0);
    endcase
  end

  // driver tasks: called at a falling edge, return at the falling edge after acceptance
  task automatic send(input logic wr, input logic [AW-1:0] idx, input logic [DW-1:0] d);
    bit done = 1'b0;
    int t = 0;
    req_vld = 1'b1; req_wr = wr; req_index = idx; req_wdata = d;
    while (!done && t < 200) begin
      if (req_rdy) done = 1'b1;
      @(negedge clk);
      t++;
    end
    req_vld = 1'b0;
    check("send_accept", done, 1'b1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(ctrl_idle && mq.size() == 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("idle_reached", ctrl_idle, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] ridx;
    // reset held with a pending request
    rst_n = 1'b0; req_vld = 1'b1; req_wr = 1'b0; req_index = 16'h0005;
    repeat (3) @(negedge clk);
    check("rst_req_rdy", req_rdy, 1'b0);
    check("rst_cen_b", arr_cen_b, 1'b1);
    check("rst_wen_b", arr_wen_b, 1'b1);
    check("rst_rsp_vld", rsp_vld, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_index", rsp_index, 16'h0);
    check("rst_clk_en", arr_clk_en, 1'b0);
    check("rst_idle", ctrl_idle, 1'b1);
    req_vld = 1'b0;
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("post_rst_req_rdy", req_rdy, 1'b1);
    check("post_rst_idle", ctrl_idle, 1'b1);

    // write then read-back, latency and pin sequence
    send(1'b1, 16'h0005, 32'h5);
    send(1'b0, 16'h0005, 32'h0);
    check("t1_wr_cen_b", arr_cen_b, 1'b0);
    check("t1_wr_wen_b", arr_wen_b, 1'b0);
    check("t1_wr_index", arr_index, 16'h0005);
    check("t1_wr_din", arr_din, 32'h5);
    check("t1_vld_c1", rsp_vld, 1'b0);
    @(negedge clk);
    check("t1_rd_cen_b", arr_cen_b, 1'b0);
    check("t1_rd_wen_b", arr_wen_b, 1'b1);
    check("t1_vld_c2", rsp_vld, 1'b0);
    @(negedge clk);
    check("t1_vld_c3", rsp_vld, 1'b0);
    @(negedge clk);
    check("t1_vld_c4", rsp_vld, 1'b1);
    check("t1_rdata", rsp_rdata, 32'h5);
    check("t1_rindex", rsp_index, 16'h0005);
    wait_idle();

    // response ordering
    got.delete();
    send(1'b1, 16'h0000, 32'hbb);
    send(1'b1, 16'h0200, 32'haa);
    send(1'b0, 16'h0200, 32'h0);
    send(1'b0, 16'h0000, 32'h0);
    wait_idle();
    check("t2_count", got.size(), 2);
    check("t2_first", got[0], {16'h0200, 32'haa});
    check("t2_second", got[1], {16'h0000, 32'hbb});

    // backpressure: only two responses may sit in the buffer
    got.delete();
    for (int i = 0; i < 4; i++) send(1'b1, AW'(16'h10 + i), DW'(32'h100 + i));
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) send(1'b0, AW'(16'h10 + i), 32'h0);
    repeat (6) @(negedge clk);
    check("t3_req_rdy_full", req_rdy, 1'b0);
    check("t3_rsp_vld", rsp_vld, 1'b1);
    check("t3_head_index", rsp_index, 16'h0010);
    check("t3_stalled", arr_cen_b, 1'b1);
    check("t3_not_idle", ctrl_idle, 1'b0);
    check("t3_none_taken", got.size(), 0);
    rdy_mode = 0;
    wait_idle();
    check("t3_count", got.size(), 4);
    for (int i = 0; i < 4; i++) check("t3_order", got[i], {AW'(16'h10 + i), DW'(32'h100 + i)});

    // all-ones boundary
    got.delete();
    send(1'b1, 16'hffff, 32'hffffffff);
    send(1'b0, 16'hffff, 32'h0);
    wait_idle();
    check("t4_count", got.size(), 1);
    check("t4_ones", got[0], {16'hffff, 32'hffffffff});

    // reset one cycle after a read issues
    send(1'b1, 16'h0040, 32'h1234);
    wait_idle();
    got.delete();
    send(1'b0, 16'h0040, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_vld", rsp_vld, 1'b0);
    check("t5_rst_cen_b", arr_cen_b, 1'b1);
    check("t5_rst_idle", ctrl_idle, 1'b1);
    check("t5_rst_req_rdy", req_rdy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_no_rsp", got.size(), 0);
    check("t5_idle", ctrl_idle, 1'b1);
    send(1'b0, 16'h0040, 32'h0);
    wait_idle();
    check("t5_count", got.size(), 1);
    check("t5_readback", got[0], {16'h0040, 32'h1234});

    // random traffic against the model
    rdy_mode = 2;
    for (int n = 0; n < 300; n++) begin
      ridx = ($urandom_range(0, 9) == 0) ? 16'hffff : AW'($urandom_range(0, 7));
      send(1'($urandom_range(0, 1)), ridx, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    rdy_mode = 0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
